spu_fetch_unit: RTL and testbench

Parametrised instruction fetch unit for the SPU front end. It sits between the local-store instruction memory and the dual-issue decoder. Each cycle it fetches an aligned bundle of `ISSUE_W` 32-bit instructions, holds fetched bundles in a small prefetch buffer, and presents them to decode with a valid/ready handshake. Branch redirects flush the buffer and restart fetch at the new PC, with slot masking for unaligned targets.

---
 rtl/spu_fetch_unit_pkg.sv | 25 ++
 rtl/spu_fetch_unit_if.sv | 36 +++
 rtl/spu_fetch_unit_buffer.sv | 66 ++++++
 rtl/spu_fetch_unit.sv | 132 +++++++++++++
 tb/tb_spu_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/spu_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// spu_pkg
// Shared types and constants for the SPU instruction fetch unit.
//   INST_W         : width of one instruction word
//   DEF_ISSUE_W    : default instructions per fetch bundle
//   DEF_LS_ADDR_W  : default local-store byte address width
//   inst_t         : one instruction word
//   fetch_entry_t  : one prefetch buffer entry (bundle, its pc, slot mask)
//                    sized for the default configuration
// ---------------------------------------------------------------------------
package spu_pkg;

    localparam int INST_W        = 32;
    localparam int DEF_ISSUE_W   = 2;
    localparam int DEF_LS_ADDR_W = 18;

    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        inst_t [DEF_ISSUE_W-1:0]  inst;
        logic [DEF_LS_ADDR_W-1:0] pc;
        logic [DEF_ISSUE_W-1:0]   mask;
    } fetch_entry_t;

endpackage

// File: rtl/spu_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// spu_fetch_unit_if
// Bundles the instruction-memory bus, the redirect input and the decode
// handshake of the fetch unit.
//   master : fetch unit side (drives imem_req/imem_addr and out_*)
//   slave  : environment side (memory, branch unit, decoder)
// ---------------------------------------------------------------------------
interface spu_fetch_unit_if
    import spu_pkg::*;
#(
    parameter int LS_ADDR_W = DEF_LS_ADDR_W,
    parameter int ISSUE_W   = DEF_ISSUE_W
);

    logic                        imem_req;
    logic [LS_ADDR_W-1:0]        imem_addr;
    logic [ISSUE_W*INST_W-1:0]   imem_rdata;
    logic                        redirect_valid;
    logic [LS_ADDR_W-1:0]        redirect_pc;
    logic                        dec_ready;
    logic                        out_valid;
    logic [ISSUE_W*INST_W-1:0]   out_inst;
    logic [LS_ADDR_W-1:0]        out_pc;
    logic [ISSUE_W-1:0]          out_mask;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_mask,
        input  imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_mask,
        output imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/spu_fetch_unit_buffer.sv
// ---------------------------------------------------------------------------
// spu_fetch_buffer
// Synchronous FIFO holding fetched bundles.
//   clk, reset : clock and synchronous active-high reset
//   push/data  : write data at the tail
//   pop        : advance the head
//   flush      : empty the FIFO, wins over push
//   count      : number of valid entries
//   head       : entry at the head (meaningful only when count != 0)
// ---------------------------------------------------------------------------
module spu_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush and reset both empty the FIFO; push/pop are ignored that cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/spu_fetch_unit.sv
// ---------------------------------------------------------------------------
// spu_fetch_unit
// Instruction fetch unit: fetches aligned bundles of ISSUE_W instructions
// from local store, buffers them and presents them to decode.
//   clk, reset  : clock and synchronous active-high reset
//   bus         : spu_fetch_unit_if.master (imem bus, redirect, decode)
//   perf_bundles: (SPU_FETCH_PERF_EN only) count of bundles popped
//   perf_stall  : (SPU_FETCH_PERF_EN only) cycles with out_valid && !dec_ready
// Optional feature macro: SPU_FETCH_PERF_EN
// ---------------------------------------------------------------------------
module spu_fetch_unit
    import spu_pkg::*;
#(
    parameter int LS_ADDR_W = DEF_LS_ADDR_W,
    parameter int ISSUE_W   = DEF_ISSUE_W,
    parameter int BUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    spu_fetch_unit_if.master   bus
`ifdef SPU_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_bundles,
    output logic [31:0]        perf_stall
`endif
);

    localparam int BUNDLE_BYTES = ISSUE_W * INST_W / 8;
    localparam int CNT_W        = $clog2(BUF_DEPTH+1);

    typedef struct packed {
        inst_t [ISSUE_W-1:0]  inst;
        logic [LS_ADDR_W-1:0] pc;
        logic [ISSUE_W-1:0]   mask;
    } entry_t;

    logic [LS_ADDR_W-1:0] fpc;
    logic [LS_ADDR_W-1:0] req_pc;
    logic                 inflight;
    logic [ISSUE_W-1:0]   pending_mask;
    logic [ISSUE_W-1:0]   redirect_mask;
    logic [LS_ADDR_W-1:0] word_off;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head_entry;

    // Credit check counts the bundle still in flight so a push never finds the buffer full
    assign bus.imem_req  = !reset && !bus.redirect_valid &&
                           ((32'(count) + 32'(inflight)) < 32'(BUF_DEPTH));
    assign bus.imem_addr = fpc;

    // A response arriving in a redirect cycle belongs to the old path and is dropped
    assign push = inflight && !bus.redirect_valid;
    assign pop  = bus.out_valid && bus.dec_ready;

    assign push_entry.inst = bus.imem_rdata;
    assign push_entry.pc   = req_pc;
    assign push_entry.mask = pending_mask;

    // Slots below the redirect target word inside its bundle are not executed
    always_comb begin
        redirect_mask = '0;
        word_off      = (bus.redirect_pc & LS_ADDR_W'(BUNDLE_BYTES-1)) >> 2;
        for (int i = 0; i < ISSUE_W; i++) begin
            redirect_mask[i] = (LS_ADDR_W'(i) >= word_off);
        end
    end

    // Fetch PC, in-flight tracking and the mask for the first bundle after a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc          <= '0;
            req_pc       <= '0;
            inflight     <= 1'b0;
            pending_mask <= '1;
        end else begin
            inflight <= bus.imem_req;
            if (bus.redirect_valid) begin
                fpc          <= bus.redirect_pc & ~LS_ADDR_W'(BUNDLE_BYTES-1);
                pending_mask <= redirect_mask;
            end else begin
                if (bus.imem_req) begin
                    fpc    <= fpc + LS_ADDR_W'(BUNDLE_BYTES);
                    req_pc <= fpc;
                end
                if (push) begin
                    pending_mask <= '1;
                end
            end
        end
    end

    spu_fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .count     (count),
        .head      (head_entry)
    );

    // Outputs are forced to zero while empty so stale storage never shows
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = bus.out_valid ? head_entry.inst : '0;
    assign bus.out_pc    = bus.out_valid ? head_entry.pc   : '0;
    assign bus.out_mask  = bus.out_valid ? head_entry.mask : '0;

`ifdef SPU_FETCH_PERF_EN
    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bundles <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_bundles <= perf_bundles + 32'd1;
            end
            if (bus.out_valid && !bus.dec_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spu_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_spu_fetch_unit
// Directed bench for spu_fetch_unit (LS_ADDR_W=18, ISSUE_W=2, BUF_DEPTH=4).
// Memory word k holds 0x1000+k. Expected bundles are queued as each step is
// set up and compared as the decoder accepts them.
// Optional feature macro: SPU_FETCH_PERF_EN
// ---------------------------------------------------------------------------
module tb_spu_fetch_unit;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    typedef struct {
        logic [17:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } exp_t;

    exp_t exp_q[$];

    spu_fetch_unit_if #(.LS_ADDR_W(18), .ISSUE_W(2)) bus ();

`ifdef SPU_FETCH_PERF_EN
    logic [31:0] perf_bundles;
    logic [31:0] perf_stall;
`endif

    spu_fetch_unit #(
        .LS_ADDR_W (18),
        .ISSUE_W   (2),
        .BUF_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef SPU_FETCH_PERF_EN
        ,
        .perf_bundles (perf_bundles),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference contents of one bundle starting at a byte address
    function automatic logic [63:0] bundleData(input logic [17:0] addr);
        logic [31:0] k;
        k = 32'(addr >> 2);
        return {32'h1000 + k + 32'd1, 32'h1000 + k};
    endfunction

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        if (bus.imem_req) begin
            bus.imem_rdata <= bundleData(bus.imem_addr);
        end
    end

    task automatic applyStimulus(input logic rv, input logic [17:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.dec_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input logic [17:0] pc, input logic [1:0] mask);
        exp_t e;
        e.pc   = pc;
        e.inst = bundleData(pc);
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    // Expects one accepted bundle per cycle, starting at the current negedge
    task automatic consumeBundles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            checkOutput("out_valid_stream", 64'(bus.out_valid), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("out_pc", 64'(bus.out_pc), 64'(e.pc));
                checkOutput("out_inst", bus.out_inst, e.inst);
                checkOutput("out_mask", 64'(bus.out_mask), 64'(e.mask));
            end
            @(negedge clk);
        end
    endtask

    // Redirect at the current negedge; returns at the negedge where the target bundle is due
    task automatic doRedirect(input logic [17:0] target, input logic [17:0] aligned);
        applyStimulus(1'b1, target, 1'b1);
        #1;
        checkOutput("redir_no_req", 64'(bus.imem_req), 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 18'h0, 1'b1);
        #1;
        checkOutput("redir_flushed", 64'(bus.out_valid), 64'd0);
        checkOutput("redir_req", 64'(bus.imem_req), 64'd1);
        checkOutput("redir_addr", 64'(bus.imem_addr), 64'(aligned));
        @(negedge clk);
        checkOutput("redir_latency", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 18'h0, 1'b1);
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_imem_req", 64'(bus.imem_req), 64'd0);
        checkOutput("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_inst", bus.out_inst, 64'd0);
        checkOutput("rst_out_pc", 64'(bus.out_pc), 64'd0);
        checkOutput("rst_out_mask", 64'(bus.out_mask), 64'd0);

        // Basic fetch: request right after reset, data two cycles later
        reset = 1'b0;
        #1;
        checkOutput("first_req", 64'(bus.imem_req), 64'd1);
        checkOutput("first_addr", 64'(bus.imem_addr), 64'd0);
        @(negedge clk);
        checkOutput("fetch_latency", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) pushExpected(18'(i * 8), 2'b11);
        consumeBundles(8);

        // Backpressure: buffer fills, requests stop, stream resumes intact
        applyStimulus(1'b0, 18'h0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("bp_count", 64'(dut.count), 64'd4);
        checkOutput("bp_req_low", 64'(bus.imem_req), 64'd0);
        checkOutput("bp_head_pc", 64'(bus.out_pc), 64'h40);
        applyStimulus(1'b0, 18'h0, 1'b1);
        for (int i = 0; i < 8; i++) pushExpected(18'(18'h40 + i * 8), 2'b11);
        consumeBundles(8);

        // Unaligned redirect: slot 0 masked in the first bundle only
        doRedirect(18'h014, 18'h010);
        pushExpected(18'h010, 2'b10);
        pushExpected(18'h018, 2'b11);
        pushExpected(18'h020, 2'b11);
        pushExpected(18'h028, 2'b11);
        consumeBundles(4);

        // Redirect while the 0x020 response is arriving: it must never surface
        applyStimulus(1'b1, 18'h018, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 18'h0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("inflight_req", 64'(bus.imem_req), 64'd1);
        checkOutput("inflight_addr", 64'(bus.imem_addr), 64'h020);
        @(negedge clk);
        checkOutput("inflight_head_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("inflight_head_pc", 64'(bus.out_pc), 64'h018);
        applyStimulus(1'b1, 18'h100, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 18'h0, 1'b1);
        #1;
        checkOutput("inflight_drop0", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        checkOutput("inflight_drop1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        pushExpected(18'h100, 2'b11);
        pushExpected(18'h108, 2'b11);
        pushExpected(18'h110, 2'b11);
        consumeBundles(3);

        // Wrap at top of local store
        doRedirect(18'h3FFF8, 18'h3FFF8);
        pushExpected(18'h3FFF8, 2'b11);
        pushExpected(18'h00000, 2'b11);
        pushExpected(18'h00008, 2'b11);
        consumeBundles(3);

        // Reset mid-stream: output empties next cycle, fetch restarts at 0
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_req", 64'(bus.imem_req), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_restart_req", 64'(bus.imem_req), 64'd1);
        checkOutput("midrst_restart_addr", 64'(bus.imem_addr), 64'd0);
        @(negedge clk);
        checkOutput("midrst_latency", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        pushExpected(18'h000, 2'b11);
        pushExpected(18'h008, 2'b11);
        consumeBundles(2);

`ifdef SPU_FETCH_PERF_EN
        // Performance counters: 3 stall cycles followed by 5 pops
        reset = 1'b1;
        applyStimulus(1'b0, 18'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 18'h0, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("perf_bundles", 64'(perf_bundles), 64'd5);
        checkOutput("perf_stall", 64'(perf_stall), 64'd3);
`endif

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
